// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one shift/subtract divider
// among NREQ requesters. It latches the winner's operands, strobes the divider
// and returns its result to the owner. Divide-by-zero is answered locally, and
// a stuck divider is cut off by a WAIT-state timeout. Every output is a flop.

// Per-requester slice: the round-robin "at or after pointer" qualifier and the
// zero-divisor flag for that requester's operands.
module div_arbiter_lane #(
  parameter int IDX   = 0,
  parameter int PW    = 1,
  parameter int WIDTH = 8
) (
  input  logic             req_i,
  input  logic [PW-1:0]    rr_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic             hi_o,
  output logic             dvs_zero_o
);
  assign hi_o       = req_i && (PW'(IDX) >= rr_i);
  assign dvs_zero_o = (dvs_i == '0);
endmodule

module div_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] dividend_in,
  input  logic [NREQ*WIDTH-1:0] divisor_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      quotient_out,
  output logic [WIDTH-1:0]      remainder_out,
  output logic                  err,
  output logic                  busy,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic                  div_valid,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder
);
  localparam int PW = (NREQ > 2) ? 2 : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [PW-1:0]                 rr_q, rr_d;
  logic [PW-1:0]                 owner_q, owner_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [NREQ-1:0]               gnt_q, gnt_d;
  logic [NREQ-1:0]               done_q, done_d;
  logic [WIDTH-1:0]              quo_q, quo_d;
  logic [WIDTH-1:0]              rem_q, rem_d;
  logic [WIDTH-1:0]              dvd_q, dvd_d;
  logic [WIDTH-1:0]              dvs_q, dvs_d;
  logic                          err_q, err_d;
  logic                          busy_q, busy_d;
  logic                          start_q, start_d;

  logic [NREQ-1:0][WIDTH-1:0]    dvd_lane, dvs_lane;
  logic [NREQ-1:0]               hi, dvs_zero;
  logic [PW-1:0]                 pick;
  logic                          found;

  // Unpack the flat operand buses and build the per-requester qualifiers.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign dvd_lane[i] = dividend_in[i*WIDTH +: WIDTH];
    assign dvs_lane[i] = divisor_in[i*WIDTH +: WIDTH];
    div_arbiter_lane #(.IDX(i), .PW(PW), .WIDTH(WIDTH)) u_lane (
      .req_i      (req[i]),
      .rr_i       (rr_q),
      .dvs_i      (dvs_lane[i]),
      .hi_o       (hi[i]),
      .dvs_zero_o (dvs_zero[i])
    );
  end

  // Round-robin pick: lowest requester at/after the pointer, else wrap to the
  // lowest requester overall.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && hi[i]) begin
        pick  = PW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        pick  = PW'(i);
        found = 1'b1;
      end
    end
  end

  // Job controller: next state plus next value of every registered output.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    err_d   = err_q;
    start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (|req) begin
          owner_d = pick;
          gnt_d   = NREQ'(1) << pick;
          dvd_d   = dvd_lane[pick];
          dvs_d   = dvs_lane[pick];
          if (dvs_zero[pick]) begin
            // Answered locally; the divider never sees this job.
            state_d = S_DONE;
            done_d  = NREQ'(1) << pick;
            quo_d   = '1;
            rem_d   = dvd_lane[pick];
            err_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            start_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A result arriving on the last allowed cycle still beats the timeout.
        if (div_valid) begin
          state_d = S_DONE;
          done_d  = gnt_q;
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          done_d  = gnt_q;
          quo_d   = '0;
          rem_d   = '0;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        rr_d    = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
    end
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign quotient_out  = quo_q;
  assign remainder_out = rem_q;
  assign err           = err_q;
  assign busy          = busy_q;
  assign div_start     = start_q;
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider with programmable latency, a
// vector table, hand sequences for the multi-cycle corners and random jobs
// checked against an arithmetic round-robin model.
module tb_div_arbiter;
  localparam int NREQ = 2;
  localparam int TO   = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] dividend_in, divisor_in;
  logic [1:0]  gnt, done;
  logic [7:0]  quotient_out, remainder_out, div_dividend, div_divisor;
  logic [7:0]  div_quotient, div_remainder;
  logic        err, busy, div_start, div_valid;

  int checks = 0, errors = 0;
  int start_cnt = 0, done_cnt = 0;
  int rr_m = 0;
  int lat = 17;
  bit never = 1'b0;
  bit inj = 1'b0;

  div_arbiter #(.NREQ(NREQ), .WIDTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .dividend_in(dividend_in),
    .divisor_in(divisor_in), .gnt(gnt), .done(done),
    .quotient_out(quotient_out), .remainder_out(remainder_out), .err(err),
    .busy(busy), .div_start(div_start), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_valid(div_valid),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  // Divider stand-in: result valid for one cycle, lat cycles after the
  // start strobe is seen; silent forever when never=1.
  logic [7:0] dm_a, dm_b, dm_q, dm_r;
  int         dm_cnt;
  logic       dm_valid;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dm_cnt <= 0; dm_valid <= 1'b0; dm_q <= '0; dm_r <= '0;
      dm_a <= '0; dm_b <= '0;
    end else begin
      dm_valid <= 1'b0;
      if (div_start) begin
        dm_a <= div_dividend; dm_b <= div_divisor;
        dm_cnt <= never ? 0 : lat;
      end else if (dm_cnt != 0) begin
        dm_cnt <= dm_cnt - 1;
        if (dm_cnt == 1) begin
          dm_valid <= 1'b1;
          dm_q <= (dm_b != 0) ? dm_a / dm_b : 8'h00;
          dm_r <= (dm_b != 0) ? dm_a % dm_b : 8'h00;
        end
      end
    end
  end
  assign div_valid     = dm_valid | inj;
  assign div_quotient  = dm_q;
  assign div_remainder = dm_r;

  typedef struct {
    logic [1:0] req;
    logic [7:0] a0, b0, a1, b1;
    int         lat;
    logic [1:0] eg;
    logic [7:0] eq, er;
    logic       ee;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock, sampled on the falling edge, with the per-cycle invariants.
  task automatic tick();
    @(negedge clk);
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
    chk("done_is_owner", 32'(done & ~gnt), 0);
    if (div_start) start_cnt++;
    if (done != 2'b00) done_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; inj = 1'b0; never = 1'b0;
    tick(); tick();
    reset = 1'b0;
    rr_m = 0;
  endtask

  function automatic int rr_pick(input logic [1:0] r, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return 0;
  endfunction

  // Run one job from an IDLE cycle and check grant, result and release.
  task automatic run_job(input string nm, input logic [1:0] r,
                         input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1,
                         input int l, input bit nv, input bit scr,
                         input logic [1:0] eg, input logic [7:0] eq,
                         input logic [7:0] er, input logic ee);
    int n;
    int s0;
    logic [7:0] bsel;
    req = r; dividend_in = {a1, a0}; divisor_in = {b1, b0};
    lat = l; never = nv;
    s0 = start_cnt;
    bsel = eg[1] ? b1 : b0;
    n = 0;
    do begin tick(); n++; end while (gnt == 2'b00 && n < 8);
    chk({nm, "_gnt"}, gnt, eg);
    if (scr) begin
      req = 2'($urandom);
      dividend_in = 16'($urandom);
    end
    n = 0;
    while (done == 2'b00 && n < TO + 12) begin tick(); n++; end
    chk({nm, "_done"}, done, eg);
    chk({nm, "_q"}, quotient_out, eq);
    chk({nm, "_r"}, remainder_out, er);
    chk({nm, "_err"}, err, ee);
    chk({nm, "_starts"}, start_cnt - s0, (bsel == 0) ? 0 : 1);
    tick();
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_gnt"}, gnt, 0);
    chk({nm, "_idle_done"}, done, 0);
    rr_m = ((eg[1] ? 1 : 0) + 1) % NREQ;
  endtask

  initial begin
    int n;
    int s0;
    int d0;
    logic [1:0] r, eg;
    logic [7:0] a0, b0, a1, b1, a, b, eq, er;
    logic ee;
    int l, o;
    bit nv;

    tbl[0] = '{2'b01, 8'd100, 8'd7,   8'd0,   8'd1,  17, 2'b01, 8'd14,  8'd2,  1'b0};
    tbl[1] = '{2'b11, 8'd200, 8'd9,   8'd50,  8'd5,  12, 2'b10, 8'd10,  8'd0,  1'b0};
    tbl[2] = '{2'b11, 8'd200, 8'd9,   8'd50,  8'd5,   5, 2'b01, 8'd22,  8'd2,  1'b0};
    tbl[3] = '{2'b10, 8'd1,   8'd1,   8'd37,  8'd0,   5, 2'b10, 8'hFF,  8'd37, 1'b1};
    tbl[4] = '{2'b10, 8'd1,   8'd1,   8'd255, 8'd1,   3, 2'b10, 8'd255, 8'd0,  1'b0};
    tbl[5] = '{2'b01, 8'd7,   8'd200, 8'd0,   8'd0,   1, 2'b01, 8'd0,   8'd7,  1'b0};
    tbl[6] = '{2'b01, 8'd0,   8'd0,   8'd5,   8'd5,   1, 2'b01, 8'hFF,  8'd0,  1'b1};
    tbl[7] = '{2'b11, 8'd9,   8'd3,   8'd255, 8'd16, 23, 2'b10, 8'd15,  8'd15, 1'b0};

    reset = 1'b1; req = 2'b00; dividend_in = '0; divisor_in = '0;
    tick(); tick();
    chk("rst_gnt", gnt, 0);          chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);        chk("rst_start", div_start, 0);
    chk("rst_q", quotient_out, 0);   chk("rst_r", remainder_out, 0);
    chk("rst_err", err, 0);          chk("rst_dvd", div_dividend, 0);
    chk("rst_dvs", div_divisor, 0);
    reset = 1'b0;

    // Basic job with exact latency.
    s0 = start_cnt;
    req = 2'b01; dividend_in = {8'd0, 8'd100}; divisor_in = {8'd1, 8'd7}; lat = 17;
    tick();
    chk("t1_gnt_c1", gnt, 2'b01); chk("t1_start_c1", div_start, 1);
    chk("t1_busy_c1", busy, 1);   chk("t1_dvd", div_dividend, 100);
    tick();
    chk("t1_start_c2", div_start, 0);
    n = 2;
    while (done == 2'b00 && n < 60) begin tick(); n++; end
    chk("t1_done_cycle", n, 17 + 3);
    chk("t1_done", done, 2'b01); chk("t1_q", quotient_out, 14);
    chk("t1_r", remainder_out, 2); chk("t1_err", err, 0);
    chk("t1_starts", start_cnt - s0, 1);
    tick();
    chk("t1_busy_after", busy, 0); chk("t1_q_held", quotient_out, 14);
    req = 2'b00;

    // Stray div_valid while idle does nothing.
    d0 = done_cnt;
    inj = 1'b1;
    tick(); tick(); tick();
    inj = 1'b0;
    chk("stray_busy", busy, 0); chk("stray_done", done_cnt - d0, 0);
    chk("stray_q", quotient_out, 14);

    do_reset();
    for (int i = 0; i < 8; i++)
      run_job($sformatf("tbl%0d", i), tbl[i].req, tbl[i].a0, tbl[i].b0,
              tbl[i].a1, tbl[i].b1, tbl[i].lat, 1'b0, 1'b0,
              tbl[i].eg, tbl[i].eq, tbl[i].er, tbl[i].ee);

    // Timeout with a silent divider, then recovery and the boundary cases.
    req = 2'b01; dividend_in = {8'd0, 8'd20}; divisor_in = {8'd1, 8'd3}; never = 1'b1;
    n = 0;
    do begin tick(); n++; end while (done == 2'b00 && n < 60);
    chk("t4_done_cycle", n, TO + 2);
    chk("t4_done", done, 2'b01); chk("t4_q", quotient_out, 0);
    chk("t4_r", remainder_out, 0); chk("t4_err", err, 1);
    tick();
    run_job("t4_next", 2'b01, 8'd20, 8'd3, 8'd0, 8'd1, 5, 1'b0, 1'b0, 2'b01, 8'd6, 8'd2, 1'b0);
    run_job("t4_late", 2'b01, 8'd20, 8'd3, 8'd0, 8'd1, TO, 1'b0, 1'b0, 2'b01, 8'd0, 8'd0, 1'b1);
    run_job("t4_after", 2'b01, 8'd20, 8'd3, 8'd0, 8'd1, 2, 1'b0, 1'b0, 2'b01, 8'd6, 8'd2, 1'b0);

    // Both requesting, held: alternation from pointer 0.
    do_reset();
    run_job("t2_a", 2'b11, 8'd200, 8'd9, 8'd50, 8'd5, 17, 1'b0, 1'b0, 2'b01, 8'd22, 8'd2, 1'b0);
    run_job("t2_b", 2'b11, 8'd200, 8'd9, 8'd50, 8'd5, 17, 1'b0, 1'b0, 2'b10, 8'd10, 8'd0, 1'b0);
    run_job("t2_c", 2'b11, 8'd200, 8'd9, 8'd50, 8'd5, 17, 1'b0, 1'b0, 2'b01, 8'd22, 8'd2, 1'b0);

    // Reset three cycles into WAIT: outputs clear at once, job lost.
    do_reset();
    req = 2'b10; dividend_in = {8'd50, 8'd0}; divisor_in = {8'd5, 8'd0}; lat = 17;
    tick();
    chk("t5_gnt", gnt, 2'b10);
    tick(); tick(); tick();
    d0 = done_cnt;
    req = 2'b11; dividend_in = {8'd50, 8'd200}; divisor_in = {8'd5, 8'd9};
    reset = 1'b1;
    #1;
    chk("t5_gnt0", gnt, 0);        chk("t5_busy0", busy, 0);
    chk("t5_dvd0", div_dividend, 0); chk("t5_dvs0", div_divisor, 0);
    chk("t5_q0", quotient_out, 0); chk("t5_err0", err, 0);
    chk("t5_done0", done, 0);
    tick();
    reset = 1'b0; rr_m = 0;
    run_job("t5_after", 2'b11, 8'd200, 8'd9, 8'd50, 8'd5, 6, 1'b0, 1'b0, 2'b01, 8'd22, 8'd2, 1'b0);
    chk("t5_done_count", done_cnt - d0, 1);

    // Owner drops req mid-job, other requester arrives.
    do_reset();
    req = 2'b01; dividend_in = {8'd9, 8'd100}; divisor_in = {8'd3, 8'd7}; lat = 10;
    tick();
    chk("t6_gnt_a", gnt, 2'b01);
    tick(); tick();
    req = 2'b10; dividend_in = {8'd9, 8'd0};
    n = 0;
    while (done == 2'b00 && n < 60) begin tick(); n++; end
    chk("t6_done_a", done, 2'b01); chk("t6_q_a", quotient_out, 14);
    chk("t6_r_a", remainder_out, 2); chk("t6_err_a", err, 0);
    n = 0;
    do begin tick(); n++; end while (gnt == 2'b00 && n < 8);
    chk("t6_gap", n, 2); chk("t6_gnt_b", gnt, 2'b10);
    n = 0;
    while (done == 2'b00 && n < 60) begin tick(); n++; end
    chk("t6_done_b", done, 2'b10); chk("t6_q_b", quotient_out, 3);
    chk("t6_r_b", remainder_out, 0);
    tick();
    rr_m = 0;

    // Random jobs against the arithmetic/round-robin model.
    for (int i = 0; i < 40; i++) begin
      r  = 2'($urandom_range(1, 3));
      a0 = 8'($urandom); a1 = 8'($urandom);
      b0 = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      b1 = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      l  = $urandom_range(1, 25);
      nv = ($urandom_range(0, 9) == 0);
      o  = rr_pick(r, rr_m);
      eg = 2'(1 << o);
      a  = (o == 1) ? a1 : a0;
      b  = (o == 1) ? b1 : b0;
      if (b == 0) begin
        eq = 8'hFF; er = a; ee = 1'b1;
      end else if (nv || l > TO - 1) begin
        eq = 8'd0; er = 8'd0; ee = 1'b1;
      end else begin
        eq = a / b; er = a % b; ee = 1'b0;
      end
      run_job($sformatf("rnd%0d", i), r, a0, b0, a1, b1, l, nv,
              1'($urandom_range(0, 1)), eg, eq, er, ee);
    end
    req = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
